mode_transition_ctrl: RTL and testbench

- Owns the processing-mode select for the gesture/image pipeline.
- Synchronizes and debounces the board switches, then decodes the thermometer pattern on sw[5:0] into a 4-bit mode code.
- Schedules each mode change at a frame boundary: flushes the pipeline, waits for it to go idle, then commits the new mode.
- Drives the active-low status LEDs from the committed mode.

---
 rtl/mode_transition_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mode_transition_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mode_transition_ctrl.sv
// Switch-driven processing-mode controller: syncs, decodes and debounces the switches, then
// commits a new mode at a frame boundary after flushing the pipeline. Define MODE6_EN for mode 6.
module mode_transition_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter int unsigned FLUSH_CYC    = 4,
    parameter int unsigned IDLE_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Switch,
    input  logic        vsync,
    input  logic        pipe_idle,
    output logic [3:0]  mode,
    output logic        mode_changed,
    output logic        pipe_flush,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] Led
);
    localparam int unsigned FlushW = $clog2(FLUSH_CYC + 1);
    localparam int unsigned WaitW  = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [19:0]        DebMax    = 20'(DEBOUNCE_CYC - 1);
    localparam logic [FlushW-1:0]  FlushLast = FlushW'(FLUSH_CYC - 1);
    localparam logic [WaitW-1:0]   WaitLast  = WaitW'(IDLE_TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StPending, StFlush, StWaitIdle, StCommit} state_e;

    function automatic logic [3:0] decode(input logic [5:0] sw);
        case (sw)
            6'b000001: decode = 4'd1;
            6'b000011: decode = 4'd2;
            6'b000111: decode = 4'd4;
            6'b001111: decode = 4'd5;
            6'b011111: decode = 4'd3;
`ifdef MODE6_EN
            6'b111111: decode = 4'd6;
`endif
            default:   decode = 4'd0;
        endcase
    endfunction

    function automatic logic [15:0] led_of(input logic [3:0] m);
        case (m)
            4'd1:    led_of = 16'hFFFE;
            4'd2:    led_of = 16'hFFFD;
            4'd4:    led_of = 16'hFFFB;
            4'd5:    led_of = 16'hFFF7;
            4'd3:    led_of = 16'hFFEF;
`ifdef MODE6_EN
            4'd6:    led_of = 16'hFFDF;
`endif
            default: led_of = 16'hFFFF;
        endcase
    endfunction

    // Only the thermometer bits are decoded; the rest of the switch bank is ignored.
    logic unused_sw;
    assign unused_sw = ^Switch[15:6];

    logic [5:0]        sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic              vsync_q, vsync_d, vsync_prev_q, vsync_prev_d;
    logic [3:0]        dec;
    logic [3:0]        dec_q, dec_d, stable_q, stable_d;
    logic [19:0]       deb_cnt_q, deb_cnt_d;
    state_e            state_q, state_d;
    logic [3:0]        target_q, target_d, mode_q, mode_d;
    logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;
    logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0]       led_q, led_d;
    logic              mode_changed_q, mode_changed_d, pipe_flush_q, pipe_flush_d;
    logic              busy_q, busy_d, timeout_err_q, timeout_err_d;
    logic              vsync_rise;

    always_comb begin
        sw_meta_d    = Switch[5:0];
        sw_sync_d    = sw_meta_q;
        vsync_d      = vsync;
        vsync_prev_d = vsync_q;
        vsync_rise   = vsync_q & ~vsync_prev_q;

        // Saturating at DebMax keeps stable_mode tracking the decode once it is settled.
        dec   = decode(sw_sync_q);
        dec_d = dec;
        if (dec != dec_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q != DebMax) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end else begin
            deb_cnt_d = deb_cnt_q;
        end
        stable_d = (deb_cnt_d == DebMax) ? dec : stable_q;

        state_d        = state_q;
        target_d       = target_q;
        flush_cnt_d    = flush_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        mode_d         = mode_q;
        led_d          = led_q;
        mode_changed_d = 1'b0;
        pipe_flush_d   = 1'b0;
        timeout_err_d  = timeout_err_q;

        unique case (state_q)
            StIdle: begin
                if (stable_q != mode_q) begin
                    state_d  = StPending;
                    target_d = stable_q;
                end
            end
            StPending: begin
                target_d = stable_q;
                if (stable_q == mode_q) begin
                    state_d = StIdle;
                end else if (vsync_rise) begin
                    state_d      = StFlush;
                    flush_cnt_d  = '0;
                    pipe_flush_d = 1'b1;
                end
            end
            StFlush: begin
                if (flush_cnt_q == FlushLast) begin
                    state_d    = StWaitIdle;
                    wait_cnt_d = '0;
                end else begin
                    flush_cnt_d  = flush_cnt_q + 1'b1;
                    pipe_flush_d = 1'b1;
                end
            end
            StWaitIdle: begin
                if (pipe_idle || (wait_cnt_q == WaitLast)) begin
                    state_d        = StCommit;
                    mode_d         = target_q;
                    led_d          = led_of(target_q);
                    mode_changed_d = 1'b1;
                    if (!pipe_idle) timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_q      <= '0;
            sw_sync_q      <= '0;
            vsync_q        <= 1'b0;
            vsync_prev_q   <= 1'b0;
            dec_q          <= '0;
            deb_cnt_q      <= '0;
            stable_q       <= '0;
            state_q        <= StIdle;
            target_q       <= '0;
            flush_cnt_q    <= '0;
            wait_cnt_q     <= '0;
            mode_q         <= '0;
            led_q          <= 16'hFFFF;
            mode_changed_q <= 1'b0;
            pipe_flush_q   <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            sw_meta_q      <= sw_meta_d;
            sw_sync_q      <= sw_sync_d;
            vsync_q        <= vsync_d;
            vsync_prev_q   <= vsync_prev_d;
            dec_q          <= dec_d;
            deb_cnt_q      <= deb_cnt_d;
            stable_q       <= stable_d;
            state_q        <= state_d;
            target_q       <= target_d;
            flush_cnt_q    <= flush_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            mode_q         <= mode_d;
            led_q          <= led_d;
            mode_changed_q <= mode_changed_d;
            pipe_flush_q   <= pipe_flush_d;
            busy_q         <= busy_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign mode         = mode_q;
    assign Led          = led_q;
    assign mode_changed = mode_changed_q;
    assign pipe_flush   = pipe_flush_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_mode_transition_ctrl.sv
// Scoreboard bench for mode_transition_ctrl: scenarios push expected commits, a monitor pops
// and compares them on each mode_changed pulse and checks flush pulse lengths.
module tb_mode_transition_ctrl;
    localparam int unsigned Deb   = 4;
    localparam int unsigned Flush = 4;
    localparam int unsigned Tmo   = 16;

    logic        clk = 1'b0;
    logic        rst, vsync, pipe_idle;
    logic [15:0] Switch;
    logic [3:0]  mode;
    logic        mode_changed, pipe_flush, busy, timeout_err;
    logic [15:0] Led;

    mode_transition_ctrl #(
        .DEBOUNCE_CYC(Deb),
        .FLUSH_CYC   (Flush),
        .IDLE_TIMEOUT(Tmo)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Switch      (Switch),
        .vsync       (vsync),
        .pipe_idle   (pipe_idle),
        .mode        (mode),
        .mode_changed(mode_changed),
        .pipe_flush  (pipe_flush),
        .busy        (busy),
        .timeout_err (timeout_err),
        .Led         (Led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  m;
        logic [15:0] led;
        logic        terr;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  model_mode;
    logic        model_terr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Spec tables: thermometer pattern -> mode, mode -> LED slot.
    function automatic logic [3:0] decode_ref(input logic [5:0] sw);
        logic [5:0] pats[6];
        logic [3:0] codes[6];
        int         n;
        pats  = '{6'b000001, 6'b000011, 6'b000111, 6'b001111, 6'b011111, 6'b111111};
        codes = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd3, 4'd6};
`ifdef MODE6_EN
        n = 6;
`else
        n = 5;
`endif
        for (int i = 0; i < n; i++) if (sw == pats[i]) return codes[i];
        return 4'd0;
    endfunction

    function automatic logic [15:0] led_ref(input logic [3:0] m);
        logic [3:0] order[6];
        order = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd3, 4'd6};
        for (int i = 0; i < 6; i++) if (m == order[i]) return ~(16'h1 << i);
        return 16'hFFFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare each commit against the scoreboard, and each flush run against Flush.
    int flush_run = 0;
    always @(negedge clk) begin
        if (rst) begin
            flush_run = 0;
        end else begin
            if (mode_changed) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_commit", {28'd0, mode}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("commit_mode", {28'd0, mode}, {28'd0, e.m});
                    check("commit_led", {16'd0, Led}, {16'd0, e.led});
                    check("commit_timeout_err", {31'd0, timeout_err}, {31'd0, e.terr});
                end
            end
            if (pipe_flush) begin
                flush_run++;
            end else if (flush_run != 0) begin
                check("flush_len", flush_run, Flush);
                flush_run = 0;
            end
        end
    end

    // One mode request: hold switches, pulse vsync, release pipe_idle after idle_delay cycles.
    task automatic change_mode(input logic [15:0] sw, input int idle_delay);
        logic [3:0] want;
        logic       tmo;
        want   = decode_ref(sw[5:0]);
        tmo    = (idle_delay >= 30);
        Switch = sw;
        repeat (Deb + 6) tick();
        if (want != model_mode) begin
            check("pending_busy", {31'd0, busy}, 32'd1);
            check("pending_no_flush", {31'd0, pipe_flush}, 32'd0);
        end
        pipe_idle = (idle_delay == 0);
        vsync     = 1'b1;
        tick();
        vsync = 1'b0;
        if (want != model_mode) begin
            model_terr = model_terr | tmo;
            exp_q.push_back('{m: want, led: led_ref(want), terr: model_terr});
            model_mode = want;
        end
        repeat (idle_delay) tick();
        pipe_idle = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        check("commit_seen", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) tick();
        check("settled_mode", {28'd0, mode}, {28'd0, model_mode});
        check("settled_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst        = 1'b0;
        model_mode = 4'd0;
        model_terr = 1'b0;
    endtask

    initial begin
        int busy_seen;
        logic [5:0] valid_pats[6];
        valid_pats = '{6'b000001, 6'b000011, 6'b000111, 6'b001111, 6'b011111, 6'b111111};
        rst = 1'b1; Switch = '0; vsync = 1'b0; pipe_idle = 1'b1;
        do_reset();
        check("rst_mode", {28'd0, mode}, 32'd0);
        check("rst_led", {16'd0, Led}, 32'h0000_FFFF);
        check("rst_mode_changed", {31'd0, mode_changed}, 32'd0);
        check("rst_pipe_flush", {31'd0, pipe_flush}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);

        // Bouncing switch never settles long enough to be accepted.
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            Switch = (i % 2 == 0) ? 16'h0001 : 16'h0000;
            tick(); busy_seen += int'(busy);
            tick(); busy_seen += int'(busy);
        end
        Switch = 16'h0000;
        repeat (Deb + 6) tick();
        check("bounce_busy_cycles", busy_seen, 0);
        check("bounce_mode", {28'd0, mode}, 32'd0);

        change_mode(16'h0001, 0);

        // Request then withdraw before any frame boundary.
        Switch = 16'h0003;
        repeat (Deb + 6) tick();
        check("cancel_pending_busy", {31'd0, busy}, 32'd1);
        Switch = 16'h0001;
        repeat (Deb + 6) tick();
        check("cancel_idle_busy", {31'd0, busy}, 32'd0);
        vsync = 1'b1; tick(); vsync = 1'b0;
        repeat (Flush + 4) tick();
        check("cancel_no_flush", {31'd0, pipe_flush}, 32'd0);
        check("cancel_mode", {28'd0, mode}, 32'd1);

        do_reset();
        change_mode(16'h001F, 40);
        repeat (10) tick();
        check("timeout_sticky", {31'd0, timeout_err}, 32'd1);

        // Reset in the middle of a flush.
        do_reset();
        Switch = 16'h0007;
        repeat (Deb + 6) tick();
        vsync = 1'b1; tick(); vsync = 1'b0;
        tick(); tick();
        check("midflush_flush_high", {31'd0, pipe_flush}, 32'd1);
        rst    = 1'b1;
        Switch = 16'h0000;
        tick();
        check("abort_mode", {28'd0, mode}, 32'd0);
        check("abort_led", {16'd0, Led}, 32'h0000_FFFF);
        check("abort_flush", {31'd0, pipe_flush}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_timeout_err", {31'd0, timeout_err}, 32'd0);
        do_reset();

        change_mode(16'h003F, 2);
        check("mode6_led", {16'd0, Led}, {16'd0, led_ref(model_mode)});

        for (int n = 0; n < 25; n++) begin
            logic [15:0] sw;
            int          d;
            sw = 16'($urandom);
            if ($urandom_range(0, 3) != 0) sw[5:0] = valid_pats[$urandom_range(0, 5)];
            d = ($urandom_range(0, 3) == 0) ? 30 + int'($urandom_range(0, 6))
                                            : int'($urandom_range(0, 12));
            change_mode(sw, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
